pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Front-end sequencer for the fetch stage. Drives the PC register's write-enable and the 4:1 next-PC select: PC+4, jump {pc_4_id, offset28}, beq target, jr target.
- Also drives the IF/ID write-enable, the IF/ID flush and the ID/EX bubble.
- Arbitrates four conditions each cycle: post-reset boot, instruction-memory wait, load-use stall, and control-flow redirect. A redirect that arrives during a memory wait is held until the fetch completes.
- Sits between the hazard unit, the ID-stage branch/jump decode and the fetch-stage PC mux.

Parameters:
- BOOT_CYCLES, 2: cycles after reset release during which the PC is held and IF/ID is flushed; legal range 1..15.
- WAIT_LIMIT, 255: maximum consecutive imem_ready=0 cycles before wait_err sets; legal range 1..65535.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- imem_ready, in, 1: instruction memory has valid data for the current PC this cycle.
- load_use, in, 1: hazard unit reports a load-use dependency in ID.
- jump, in, 1: the ID instruction is j or jal.
- beq_taken, in, 1: the ID branch resolved taken.
- jr, in, 1: the ID instruction is jr.
- pc_write, out, 1: PC register write-enable.
- pc_src, out, 2: next-PC select. 0 = PC+4, 1 = jump, 2 = beq, 3 = jr.
- if_id_write, out, 1: IF/ID register write-enable.
- if_flush, out, 1: load a NOP into IF/ID.
- id_ex_bubble, out, 1: insert a NOP into ID/EX.
- wait_err, out, 1: sticky memory-wait timeout flag.

Behaviour:
- Reset (synchronous, active-high):
  - Enter BOOT; boot counter loads BOOT_CYCLES-1.
  - pend_valid=0, pend_src=0, wait counter=0, wait_err=0.
  - Outputs during the reset cycle: pc_write=0, pc_src=0, if_id_write=1, if_flush=1, id_ex_bubble=1.
- Outputs are combinational from state plus inputs; state is registered.
- Redirect request:
  - req = jump | beq_taken | jr.
  - req_src priority when several are high: jr (3) > beq (2) > jump (1).
- States and transitions:
  - BOOT: pc_write=0, if_flush=1, if_id_write=1, id_ex_bubble=1. Counter decrements each cycle; at 0, go to RUN. Inputs are ignored.
  - RUN, evaluated in priority order:
    1. imem_ready=0: pc_write=0, if_id_write=0, id_ex_bubble=1. If req and not load_use, latch pend_valid=1 and pend_src=req_src. Go to IWAIT.
    2. load_use=1: pc_write=0, if_id_write=0, id_ex_bubble=1. The redirect is suppressed because the branch operand is not ready.
    3. pend_valid=1: pc_write=1, pc_src=pend_src, if_flush=1, if_id_write=1. Clear pend_valid; live req is ignored this cycle.
    4. req=1: pc_write=1, pc_src=req_src, if_flush=1, if_id_write=1.
    5. Otherwise: pc_write=1, pc_src=0, if_id_write=1.
  - IWAIT: same outputs as RUN case 1.
    - The wait counter increments while imem_ready=0.
    - If the counter reaches WAIT_LIMIT, wait_err sets (sticky until reset) and the state remains IWAIT.
    - A new req while pend_valid=0 and load_use=0 latches as in RUN case 1. An already-latched pending redirect is never overwritten.
    - On imem_ready=1: clear the wait counter, return to RUN, and evaluate RUN the same cycle. The pending redirect therefore applies on the first ready cycle unless load_use=1, in which case it is held.
- Always-true rules:
  - if_flush=1 implies pc_write=1 or state=BOOT.
  - id_ex_bubble=1 implies if_id_write=0 or state=BOOT.
  - pc_src=0 whenever pc_write=0.
- Reset mid-IWAIT: the pending redirect is discarded, no PC write occurs that cycle, and the block re-enters BOOT.

Optional Feature:
- Macro PC_CTRL_PERF_EN.
- When defined, adds three output ports, each CNT_W-bit, wrapping, cleared by reset:
  - stall_cnt: cycles with load_use stall.
  - wait_cnt: cycles in IWAIT.
  - redirect_cnt: cycles with if_flush=1 outside BOOT.
- When undefined, these ports and their registers are absent and all other behaviour is identical.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - State encoding: BOOT=2'd0, RUN=2'd1, IWAIT=2'd2.
  - pc_src constants: PC_SRC_SEQ=0, PC_SRC_JUMP=1, PC_SRC_BEQ=2, PC_SRC_JR=3.
  - These constants are shared with the fetch-stage mux.
- Sub-module pc_ctrl_perf: the three counters, instantiated only under PC_CTRL_PERF_EN.

Test Plan:
- Boot: reset high 1 cycle, then low, imem_ready=1 -> pc_write=0 and if_flush=1 for cycles 0..1; cycle 2 gives pc_write=1, pc_src=0.
- Simultaneous redirects: RUN with jump=1, beq_taken=1 together -> pc_src=2, if_flush=1, pc_write=1. Next cycle, jr=1 alone -> pc_src=3.
- Load-use over branch: load_use=1 with beq_taken=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1, no flush. Next cycle load_use=0, beq_taken=1 -> pc_src=2, if_flush=1.
- Redirect during wait: imem_ready=0 for 3 cycles; jump=1 in wait cycle 1, then beq_taken=1 in wait cycle 2 -> no PC write during wait. First ready cycle gives pc_src=1, if_flush=1, ignoring beq; the following cycle gives pc_src=0.
- Timeout: WAIT_LIMIT=4, imem_ready=0 for 6 cycles -> wait_err rises after 4 wait cycles and stays 1 after imem_ready returns. Reset clears it.
- Reset mid-wait: pending jr latched, reset asserted -> pending discarded, BOOT re-entered, first post-boot pc_src=0. With PC_CTRL_PERF_EN, wait_cnt reads 0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared state encoding and next-PC select constants for pc_ctrl
// Also used by the fetch-stage PC mux.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_IWAIT = 2'd2
    } state_e;

    localparam int PC_SRC_W = 2;

    localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP = 2'd1;
    localparam logic [PC_SRC_W-1:0] PC_SRC_BEQ  = 2'd2;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JR   = 2'd3;

    localparam int BOOT_W = 4;
    localparam int WAIT_W = 16;

    // jr outranks beq, which outranks jump, when the ID stage raises several at once.
    function automatic logic [PC_SRC_W-1:0] redirect_src(
        input logic jump,
        input logic beq_taken,
        input logic jr
    );
        if (jr) begin
            return PC_SRC_JR;
        end else if (beq_taken) begin
            return PC_SRC_BEQ;
        end else if (jump) begin
            return PC_SRC_JUMP;
        end
        return PC_SRC_SEQ;
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - hazard/decode inputs and fetch-control outputs of pc_ctrl
// master = surrounding pipeline, slave = pc_ctrl.
interface pc_ctrl_if;
    import pc_ctrl_pkg::*;

    logic                imem_ready;
    logic                load_use;
    logic                jump;
    logic                beq_taken;
    logic                jr;
    logic                pc_write;
    logic [PC_SRC_W-1:0] pc_src;
    logic                if_id_write;
    logic                if_flush;
    logic                id_ex_bubble;
    logic                wait_err;

    modport master (
        output imem_ready, load_use, jump, beq_taken, jr,
        input  pc_write, pc_src, if_id_write, if_flush, id_ex_bubble, wait_err
    );

    modport slave (
        input  imem_ready, load_use, jump, beq_taken, jr,
        output pc_write, pc_src, if_id_write, if_flush, id_ex_bubble, wait_err
    );

endinterface

// File: rtl/pc_ctrl_perf.sv
// rtl/pc_ctrl_perf.sv - wrapping stall / wait / redirect event counters for pc_ctrl
// Instantiated only when PC_CTRL_PERF_EN is defined.
module pc_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             wait_i,
    input  logic             redirect_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] redirect_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q    <= '0;
            wait_q     <= '0;
            redirect_q <= '0;
        end else begin
            stall_q    <= stall_q + CNT_W'(stall_i);
            wait_q     <= wait_q + CNT_W'(wait_i);
            redirect_q <= redirect_q + CNT_W'(redirect_i);
        end
    end

    assign stall_cnt_o    = stall_q;
    assign wait_cnt_o     = wait_q;
    assign redirect_cnt_o = redirect_q;

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch-stage PC / IF-ID / ID-EX sequencer with boot, imem wait, load-use and redirect arbitration
// Optional performance counters: PC_CTRL_PERF_EN.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int WAIT_LIMIT  = 255
`ifdef PC_CTRL_PERF_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    pc_ctrl_if.slave         bus
`ifdef PC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic [CNT_W-1:0] redirect_cnt
`endif
);

    localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_e              state_q, state_d;
    logic [BOOT_W-1:0]   boot_q, boot_d;
    logic                pend_valid_q, pend_valid_d;
    logic [PC_SRC_W-1:0] pend_src_q, pend_src_d;
    logic [WAIT_W-1:0]   wait_ctr_q, wait_ctr_d;
    logic                wait_err_q, wait_err_d;

    logic                req;
    logic [PC_SRC_W-1:0] req_src;
    logic                pc_write_w;
    logic [PC_SRC_W-1:0] pc_src_w;
    logic                if_id_write_w;
    logic                if_flush_w;
    logic                id_ex_bubble_w;

    assign req     = bus.jump | bus.beq_taken | bus.jr;
    assign req_src = redirect_src(bus.jump, bus.beq_taken, bus.jr);

    always_comb begin
        state_d        = state_q;
        boot_d         = boot_q;
        pend_valid_d   = pend_valid_q;
        pend_src_d     = pend_src_q;
        wait_ctr_d     = wait_ctr_q;
        wait_err_d     = wait_err_q;
        pc_write_w     = 1'b0;
        pc_src_w       = PC_SRC_SEQ;
        if_id_write_w  = 1'b1;
        if_flush_w     = 1'b0;
        id_ex_bubble_w = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if_flush_w     = 1'b1;
                id_ex_bubble_w = 1'b1;
                if (boot_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_d = boot_q - BOOT_W'(1);
                end
            end
            // IWAIT resolves exactly like RUN, so a fetch that completes is handled in the same cycle.
            ST_RUN, ST_IWAIT: begin
                if (!bus.imem_ready) begin
                    if_id_write_w  = 1'b0;
                    id_ex_bubble_w = 1'b1;
                    state_d        = ST_IWAIT;
                    if (req && !bus.load_use && !pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_src_d   = req_src;
                    end
                    if (wait_ctr_q != WAIT_MAX) begin
                        wait_ctr_d = wait_ctr_q + WAIT_ONE;
                    end
                    if (wait_ctr_q >= WAIT_MAX - WAIT_ONE) begin
                        wait_err_d = 1'b1;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_ctr_d = '0;
                    if (bus.load_use) begin
                        if_id_write_w  = 1'b0;
                        id_ex_bubble_w = 1'b1;
                    end else if (pend_valid_q) begin
                        pc_write_w   = 1'b1;
                        pc_src_w     = pend_src_q;
                        if_flush_w   = 1'b1;
                        pend_valid_d = 1'b0;
                    end else if (req) begin
                        pc_write_w = 1'b1;
                        pc_src_w   = req_src;
                        if_flush_w = 1'b1;
                    end else begin
                        pc_write_w = 1'b1;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // The reset cycle already presents boot outputs, so no PC write can slip through.
        if (reset) begin
            pc_write_w     = 1'b0;
            pc_src_w       = PC_SRC_SEQ;
            if_id_write_w  = 1'b1;
            if_flush_w     = 1'b1;
            id_ex_bubble_w = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            boot_q       <= BOOT_INIT;
            pend_valid_q <= 1'b0;
            pend_src_q   <= PC_SRC_SEQ;
            wait_ctr_q   <= '0;
            wait_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            boot_q       <= boot_d;
            pend_valid_q <= pend_valid_d;
            pend_src_q   <= pend_src_d;
            wait_ctr_q   <= wait_ctr_d;
            wait_err_q   <= wait_err_d;
        end
    end

    assign bus.pc_write     = pc_write_w;
    assign bus.pc_src       = pc_src_w;
    assign bus.if_id_write  = if_id_write_w;
    assign bus.if_flush     = if_flush_w;
    assign bus.id_ex_bubble = id_ex_bubble_w;
    assign bus.wait_err     = wait_err_q;

`ifdef PC_CTRL_PERF_EN
    logic stall_ev;
    logic wait_ev;
    logic redirect_ev;

    assign stall_ev    = (state_q == ST_RUN || state_q == ST_IWAIT) && bus.imem_ready && bus.load_use;
    assign wait_ev     = (state_q == ST_IWAIT);
    assign redirect_ev = if_flush_w && (state_q != ST_BOOT) && !reset;

    pc_ctrl_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_ev),
        .wait_i        (wait_ev),
        .redirect_i    (redirect_ev),
        .stall_cnt_o   (stall_cnt),
        .wait_cnt_o    (wait_cnt),
        .redirect_cnt_o(redirect_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - directed and randomized check of pc_ctrl against a cycle-level reference model
module tb_pc_ctrl;

    localparam int BOOT = 2;
    localparam int WLIM = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_ctrl_if bus();

`ifdef PC_CTRL_PERF_EN
    logic [31:0] stall_cnt, wait_cnt, redirect_cnt;
`endif

    pc_ctrl #(
        .BOOT_CYCLES(BOOT),
        .WAIT_LIMIT (WLIM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef PC_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .wait_cnt    (wait_cnt),
        .redirect_cnt(redirect_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_boot = 0;
    bit          m_pv   = 1'b0;
    bit [1:0]    m_ps   = 2'd0;
    int          m_nr   = 0;
    bit          m_err  = 1'b0;
    bit          m_in_wait = 1'b0;
    int unsigned m_stall = 0, m_wait = 0, m_redir = 0;

    // {pc_write, pc_src[1:0], if_id_write, if_flush, id_ex_bubble, wait_err}
    logic [6:0] obs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit lu, input bit j, input bit b,
                        input bit jri, input string tag);
        logic [6:0] want;
        bit         req;
        bit [1:0]   src;
        bit         boot_now;
        @(negedge clk);
        reset          = r;
        bus.imem_ready = rdy;
        bus.load_use   = lu;
        bus.jump       = j;
        bus.beq_taken  = b;
        bus.jr         = jri;
        #1;
        obs = {bus.pc_write, bus.pc_src, bus.if_id_write, bus.if_flush, bus.id_ex_bubble, bus.wait_err};
        req = j | b | jri;
        src = jri ? 2'd3 : (b ? 2'd2 : (j ? 2'd1 : 2'd0));
        boot_now = r || (m_boot > 0);
        if (boot_now)      want = {1'b0, 2'd0, 1'b1, 1'b1, 1'b1, m_err};
        else if (!rdy)     want = {1'b0, 2'd0, 1'b0, 1'b0, 1'b1, m_err};
        else if (lu)       want = {1'b0, 2'd0, 1'b0, 1'b0, 1'b1, m_err};
        else if (m_pv)     want = {1'b1, m_ps, 1'b1, 1'b1, 1'b0, m_err};
        else if (req)      want = {1'b1, src,  1'b1, 1'b1, 1'b0, m_err};
        else               want = {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, m_err};
        check(tag, 32'(obs), 32'(want));
`ifdef PC_CTRL_PERF_EN
        check({tag, "_cnt"}, 32'({stall_cnt[7:0], wait_cnt[7:0], redirect_cnt[7:0]}),
              32'({m_stall[7:0], m_wait[7:0], m_redir[7:0]}));
`endif
        if (r) begin
            m_stall = 0; m_wait = 0; m_redir = 0;
        end else begin
            if (!boot_now && rdy && lu) m_stall++;
            if (m_in_wait) m_wait++;
            if (!boot_now && want[2]) m_redir++;
        end
        m_in_wait = !boot_now && !rdy;
        if (r) begin
            m_boot = BOOT; m_pv = 1'b0; m_ps = 2'd0; m_nr = 0; m_err = 1'b0;
        end else if (m_boot > 0) begin
            m_boot--;
        end else if (!rdy) begin
            if (req && !lu && !m_pv) begin
                m_pv = 1'b1;
                m_ps = src;
            end
            m_nr++;
            if (m_nr >= WLIM) m_err = 1'b1;
        end else begin
            m_nr = 0;
            if (!lu && m_pv) m_pv = 1'b0;
        end
    endtask

    initial begin
        bus.imem_ready = 1'b1;
        bus.load_use   = 1'b0;
        bus.jump       = 1'b0;
        bus.beq_taken  = 1'b0;
        bus.jr         = 1'b0;
        repeat (2) @(posedge clk);

        step(1, 1, 0, 0, 0, 0, "reset");
        check("reset_out", 32'(obs[6:1]), 32'(6'b0_00_111));
        step(0, 1, 0, 0, 0, 0, "boot0");
        check("boot0_hold", 32'({obs[6], obs[2]}), 32'(2'b01));
        step(0, 1, 0, 0, 0, 0, "boot1");
        check("boot1_hold", 32'({obs[6], obs[2]}), 32'(2'b01));
        step(0, 1, 0, 0, 0, 0, "run0");
        check("run0_seq", 32'(obs[6:4]), 32'(3'b100));

        step(0, 1, 0, 1, 1, 0, "jump_beq");
        check("jump_beq_sel", 32'(obs[6:2]), 32'(5'b1_10_1_1));
        step(0, 1, 0, 0, 0, 1, "jr_alone");
        check("jr_sel", 32'(obs[5:4]), 32'd3);

        step(0, 1, 1, 0, 1, 0, "lu_beq");
        check("lu_hold", 32'(obs[6:1]), 32'(6'b0_00_001));
        step(0, 1, 0, 0, 1, 0, "lu_release");
        check("lu_release_sel", 32'({obs[5:4], obs[2]}), 32'(3'b10_1));

        step(0, 0, 0, 0, 0, 0, "wait0");
        step(0, 0, 0, 1, 0, 0, "wait1");
        check("wait1_nowrite", 32'(obs[6]), 32'd0);
        step(0, 0, 0, 0, 1, 0, "wait2");
        check("wait2_nowrite", 32'(obs[6]), 32'd0);
        step(0, 1, 0, 0, 1, 0, "wait_ready");
        check("wait_pending_jump", 32'(obs[6:2]), 32'(5'b1_01_1_1));
        step(0, 1, 0, 0, 0, 0, "wait_after");
        check("wait_after_seq", 32'(obs[6:4]), 32'(3'b100));

        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 0, "timeout");
            check("timeout_err", 32'(obs[0]), (i >= WLIM) ? 32'd1 : 32'd0);
        end
        step(0, 1, 0, 0, 0, 0, "timeout_ready");
        check("err_sticky", 32'(obs[0]), 32'd1);
        step(1, 1, 0, 0, 0, 0, "timeout_reset");
        step(0, 1, 0, 0, 0, 0, "post_reset_boot0");
        check("err_cleared", 32'(obs[0]), 32'd0);
        step(0, 1, 0, 0, 0, 0, "post_reset_boot1");
        step(0, 1, 0, 0, 0, 0, "post_reset_run");

        step(0, 0, 0, 0, 0, 1, "mw_jr");
        step(0, 0, 0, 0, 0, 0, "mw_hold");
        step(1, 0, 0, 0, 0, 0, "mw_reset");
        check("mw_reset_nowrite", 32'(obs[6]), 32'd0);
        step(0, 1, 0, 0, 0, 0, "mw_boot0");
`ifdef PC_CTRL_PERF_EN
        check("mw_wait_cnt", wait_cnt, 32'd0);
`endif
        step(0, 1, 0, 0, 0, 0, "mw_boot1");
        step(0, 1, 0, 0, 0, 0, "mw_run");
        check("mw_discarded", 32'(obs[6:2]), 32'(5'b1_00_1_0));

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) == 0), ($urandom_range(9) >= 3), ($urandom_range(4) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
